// File: rtl/uart_axil_pkg.sv
// uart_axil_pkg
// Shared definitions for the two-client AXI4-Lite master that fronts the
// AXI-Lite UART.
// Contents:
//   state_t          - master sequencer states
//   AXI_RESP_*       - AXI response codes
//   RX_DATA, TX_DATA - UART register byte offsets
//   AXI_PROT_DEFAULT - AxPROT value driven on every access
package uart_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR  = 2'b10;

    localparam logic [31:0] RX_DATA          = 32'h0000_0000;
    localparam logic [31:0] TX_DATA          = 32'h0000_0004;

    localparam logic [2:0]  AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/uart_axil_rr_arb2.sv
// uart_axil_rr_arb2
// Two-client round-robin arbiter: combinational grant plus the last_grant
// pointer. A single requester always wins; with both requesting, the client
// that did not win last time is granted.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset (last_grant -> 1)
//   req[1:0]     - request lines
//   accept       - grant is being consumed this cycle; update last_grant
//   grant_valid  - at least one request present
//   grant        - index of the granted client
//   last_grant   - index of the most recently consumed grant
module uart_axil_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant,
    output logic       last_grant
);

    logic last_grant_r;

    assign last_grant = last_grant_r;

    // Grant decode from the request pair and the round-robin pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        case (req)
            2'b01: begin
                grant_valid = 1'b1;
                grant       = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant       = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant       = ~last_grant_r;
            end
            default: begin
                grant_valid = 1'b0;
                grant       = 1'b0;
            end
        endcase
    end

    // Round-robin pointer; resets to 1 so client 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (accept && grant_valid) begin
            last_grant_r <= grant;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/uart_axil_master_arb.sv
// uart_axil_master_arb
// Lets two on-chip clients share one AXI4-Lite master port to the UART.
// One single-beat transaction is in flight at a time; clients are served
// round-robin and each gets a one-cycle completion pulse.
// Ports:
//   s_axi_aclk, s_axi_aresetn  - clock, synchronous active-low reset
//   req_valid/ready/write      - per-client request handshake and type
//   req_addr, req_wdata        - per-client payload, client 0 in low slice
//   rsp_valid                  - per-client completion pulse
//   rsp_rdata, rsp_resp        - shared completion data/response
//   m_axi_*                    - AXI4-Lite master channels AW, W, B, AR, R
module uart_axil_master_arb
    import uart_axil_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_write,
    input  logic [2*P_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*P_DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                rsp_valid,
    output logic [P_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [P_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [P_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [P_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [P_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [P_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    state_t                    state_r, state_nx;
    logic [P_ADDR_WIDTH-1:0]   addr_r, addr_nx;
    logic [P_DATA_WIDTH-1:0]   wdata_r, wdata_nx;
    logic                      awvalid_r, awvalid_nx;
    logic                      wvalid_r, wvalid_nx;
    logic                      bready_r, bready_nx;
    logic                      arvalid_r, arvalid_nx;
    logic                      rready_r, rready_nx;
    logic [1:0]                rsp_valid_r, rsp_valid_nx;
    logic [P_DATA_WIDTH-1:0]   rsp_rdata_r, rsp_rdata_nx;
    logic [1:0]                rsp_resp_r, rsp_resp_nx;

    logic                      grant_valid_s;
    logic                      grant_s;
    logic                      last_grant_s;
    logic                      accept_s;
    logic                      write_sel_s;
    logic [P_ADDR_WIDTH-1:0]   addr_sel_s;
    logic [P_DATA_WIDTH-1:0]   wdata_sel_s;

    uart_axil_rr_arb2 u_arb (
        .clk         (s_axi_aclk),
        .rst_n       (s_axi_aresetn),
        .req         (req_valid),
        .accept      (accept_s),
        .grant_valid (grant_valid_s),
        .grant       (grant_s),
        .last_grant  (last_grant_s)
    );

    // Requests are only taken in IDLE and never while reset is asserted.
    assign accept_s    = (state_r == ST_IDLE) && grant_valid_s && s_axi_aresetn;
    assign req_ready   = accept_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;
    assign write_sel_s = grant_s ? req_write[1] : req_write[0];
    assign addr_sel_s  = grant_s ? req_addr[2*P_ADDR_WIDTH-1:P_ADDR_WIDTH]
                                 : req_addr[P_ADDR_WIDTH-1:0];
    assign wdata_sel_s = grant_s ? req_wdata[2*P_DATA_WIDTH-1:P_DATA_WIDTH]
                                 : req_wdata[P_DATA_WIDTH-1:0];

    assign m_axi_awaddr  = addr_r;
    assign m_axi_araddr  = addr_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_awprot  = AXI_PROT_DEFAULT;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_wstrb   = {(P_DATA_WIDTH/8){1'b1}};
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_resp      = rsp_resp_r;

    // Next-state and next-output decode; all AXI outputs are registered so
    // each valid/ready value is the one the slave sees across the next edge.
    always_comb begin
        state_nx     = state_r;
        addr_nx      = addr_r;
        wdata_nx     = wdata_r;
        awvalid_nx   = awvalid_r;
        wvalid_nx    = wvalid_r;
        bready_nx    = 1'b0;
        arvalid_nx   = arvalid_r;
        rready_nx    = 1'b0;
        rsp_valid_nx = 2'b00;
        rsp_rdata_nx = rsp_rdata_r;
        rsp_resp_nx  = rsp_resp_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_nx  = addr_sel_s;
                    wdata_nx = wdata_sel_s;
                    if (write_sel_s) begin
                        state_nx   = ST_WR_AW_W;
                        awvalid_nx = 1'b1;
                        wvalid_nx  = 1'b1;
                    end else begin
                        state_nx   = ST_RD_AR;
                        arvalid_nx = 1'b1;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WR_AW_W: begin
                // AW and W complete independently, in either order.
                if (awvalid_r && m_axi_awready) begin
                    awvalid_nx = 1'b0;
                end else begin
                    awvalid_nx = awvalid_r;
                end
                if (wvalid_r && m_axi_wready) begin
                    wvalid_nx = 1'b0;
                end else begin
                    wvalid_nx = wvalid_r;
                end
                if (!awvalid_nx && !wvalid_nx) begin
                    state_nx  = ST_WR_B;
                    bready_nx = 1'b1;
                end else begin
                    state_nx  = ST_WR_AW_W;
                end
            end
            ST_WR_B: begin
                if (m_axi_bvalid && bready_r) begin
                    state_nx     = ST_RSP;
                    rsp_valid_nx = last_grant_s ? 2'b10 : 2'b01;
                    rsp_rdata_nx = {P_DATA_WIDTH{1'b0}};
                    rsp_resp_nx  = m_axi_bresp;
                end else begin
                    bready_nx = 1'b1;
                end
            end
            ST_RD_AR: begin
                if (m_axi_arready) begin
                    arvalid_nx = 1'b0;
                    state_nx   = ST_RD_R;
                    rready_nx  = 1'b1;
                end else begin
                    arvalid_nx = 1'b1;
                end
            end
            ST_RD_R: begin
                if (m_axi_rvalid && rready_r) begin
                    state_nx     = ST_RSP;
                    rsp_valid_nx = last_grant_s ? 2'b10 : 2'b01;
                    rsp_rdata_nx = m_axi_rdata;
                    rsp_resp_nx  = m_axi_rresp;
                end else begin
                    rready_nx = 1'b1;
                end
            end
            ST_RSP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx   = ST_IDLE;
                awvalid_nx = 1'b0;
                wvalid_nx  = 1'b0;
                arvalid_nx = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops every valid/ready at once.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_r     <= ST_IDLE;
            addr_r      <= {P_ADDR_WIDTH{1'b0}};
            wdata_r     <= {P_DATA_WIDTH{1'b0}};
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 2'b00;
            rsp_rdata_r <= {P_DATA_WIDTH{1'b0}};
            rsp_resp_r  <= 2'b00;
        end else begin
            state_r     <= state_nx;
            addr_r      <= addr_nx;
            wdata_r     <= wdata_nx;
            awvalid_r   <= awvalid_nx;
            wvalid_r    <= wvalid_nx;
            bready_r    <= bready_nx;
            arvalid_r   <= arvalid_nx;
            rready_r    <= rready_nx;
            rsp_valid_r <= rsp_valid_nx;
            rsp_rdata_r <= rsp_rdata_nx;
            rsp_resp_r  <= rsp_resp_nx;
        end
    end

endmodule

// File: tb/tb_uart_axil_master_arb.sv
// tb_uart_axil_master_arb
// Directed bench for uart_axil_master_arb with a small AXI-Lite UART slave
// model (TX_DATA at 0x4 loops back to RX_DATA at 0x0, 0x8 answers SLVERR)
// and configurable ready/valid delays.
module tb_uart_axil_master_arb;

    logic        clk;
    logic        aresetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_checks;
    int n_fail;

    uart_axil_master_arb #(.P_ADDR_WIDTH(32), .P_DATA_WIDTH(32)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model (drives on negedge) ----------------
    int          aw_delay, w_delay, r_delay;
    int          aw_cnt, w_cnt, r_cnt;
    logic        prev_awvalid, prev_wvalid, prev_arvalid, prev_bready, prev_rready;
    logic        aw_done, w_done, r_pending;
    logic [31:0] aw_cap, w_cap, ar_cap, tx_reg;

    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        aw_cnt = 0; w_cnt = 0; r_cnt = 0;
        prev_awvalid = 1'b0; prev_wvalid = 1'b0; prev_arvalid = 1'b0;
        prev_bready = 1'b0; prev_rready = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; r_pending = 1'b0;
        aw_cap = 32'h0; w_cap = 32'h0; ar_cap = 32'h0; tx_reg = 32'h0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
                aw_cnt = 0; w_cnt = 0; r_cnt = 0;
                aw_done = 1'b0; w_done = 1'b0; r_pending = 1'b0;
                prev_awvalid = 1'b0; prev_wvalid = 1'b0; prev_arvalid = 1'b0;
                prev_bready = 1'b0; prev_rready = 1'b0;
            end else begin
                if (awready && prev_awvalid) begin
                    awready = 1'b0; aw_cnt = 0; aw_done = 1'b1;
                end else if (awvalid && !awready) begin
                    if (aw_cnt == aw_delay) begin awready = 1'b1; aw_cap = awaddr; end
                    else aw_cnt++;
                end
                if (wready && prev_wvalid) begin
                    wready = 1'b0; w_cnt = 0; w_done = 1'b1;
                end else if (wvalid && !wready) begin
                    if (w_cnt == w_delay) begin wready = 1'b1; w_cap = wdata; end
                    else w_cnt++;
                end
                if (bvalid && prev_bready) begin
                    bvalid = 1'b0;
                end else if (aw_done && w_done && !bvalid) begin
                    bvalid = 1'b1;
                    bresp  = (aw_cap == 32'h8) ? 2'b10 : 2'b00;
                    if (aw_cap == 32'h4) tx_reg = w_cap;
                    aw_done = 1'b0; w_done = 1'b0;
                end
                if (arready && prev_arvalid) begin
                    arready = 1'b0; r_pending = 1'b1; r_cnt = 0;
                end else if (arvalid && !arready) begin
                    arready = 1'b1; ar_cap = araddr;
                end
                if (rvalid && prev_rready) begin
                    rvalid = 1'b0; r_pending = 1'b0;
                end else if (r_pending && !rvalid) begin
                    if (r_cnt == r_delay) begin
                        rvalid = 1'b1;
                        rdata  = (ar_cap == 32'h0) ? tx_reg : 32'hDEAD_BEEF;
                        rresp  = 2'b00;
                    end else r_cnt++;
                end
                prev_awvalid = awvalid; prev_wvalid = wvalid; prev_arvalid = arvalid;
                prev_bready = bready; prev_rready = rready;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [1:0] grant_q[$];
    logic [1:0] rsp_q[$];
    int onehot_err, busy_err, order_err, rsp_err;
    int aw_hi, w_hi, ar_hi, rr_hi;

    initial begin
        onehot_err = 0; busy_err = 0; order_err = 0; rsp_err = 0;
        aw_hi = 0; w_hi = 0; ar_hi = 0; rr_hi = 0;
        forever begin
            @(negedge clk);
            if (req_ready == 2'b11) onehot_err++;
            if ((req_ready != 2'b00) &&
                (awvalid || wvalid || bready || arvalid || rready || (rsp_valid != 2'b00))) busy_err++;
            if ((req_ready & req_valid) != 2'b00) grant_q.push_back(req_ready[1] ? 2'd1 : 2'd0);
            if (rsp_valid != 2'b00) begin
                rsp_q.push_back(rsp_valid[1] ? 2'd1 : 2'd0);
                if (rsp_valid == 2'b11) rsp_err++;
            end
            if (bready && (awvalid || wvalid)) order_err++;
            if (awvalid) aw_hi++;
            if (wvalid)  w_hi++;
            if (arvalid) ar_hi++;
            if (rready)  rr_hi++;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a posedge; returns just after the accepting edge.
    task automatic issue(input int c, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
        logic acc;
        acc = 1'b0;
        req_write[c] = wr;
        req_addr[c*32 +: 32]  = a;
        req_wdata[c*32 +: 32] = d;
        req_valid[c] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[c]) begin acc = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid[c] = 1'b0;
        check({tag, "_accept"}, {63'd0, acc}, 64'd1);
    endtask

    task automatic wait_rsp(output logic [1:0] v, output logic [31:0] d, output logic [1:0] r);
        v = 2'b00; d = 32'h0; r = 2'b00;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                v = rsp_valid; d = rsp_rdata; r = rsp_resp;
                break;
            end
        end
    endtask

    task automatic wait_grants(input int base, input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (grant_q.size() - base >= n) break;
        end
    endtask

    // ---------------- main sequence ----------------
    logic [1:0]  v, r;
    logic [31:0] d;
    int gbase, rbase, b0, b1;
    logic [1:0] gv;

    initial begin
        n_checks = 0; n_fail = 0;
        aresetn = 1'b0; req_valid = 2'b00; req_write = 2'b00;
        req_addr = 64'h0; req_wdata = 64'h0;
        aw_delay = 0; w_delay = 0; r_delay = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {56'd0, req_ready, rsp_valid, rsp_resp, awvalid, wvalid},   64'd0);
        check("rst_ch",   {59'd0, bready, arvalid, rready, awprot == 3'b000, arprot == 3'b000}, 64'd3);
        check("rst_data", {rsp_rdata, awaddr | araddr | wdata}, 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;

        // client 0 writes 6 to TX_DATA, zero-wait slave
        issue(0, 1'b1, 32'h4, 32'h6, "t1");
        @(negedge clk);
        check("t1_valids", {62'd0, awvalid, wvalid}, 64'd3);
        check("t1_awaddr", {32'd0, awaddr}, 64'h4);
        check("t1_wdata",  {32'd0, wdata},  64'h6);
        check("t1_wstrb",  {60'd0, wstrb},  64'hF);
        wait_rsp(v, d, r);
        check("t1_rspv",  {62'd0, v}, 64'd1);
        check("t1_resp",  {62'd0, r}, 64'd0);
        check("t1_rdata", {32'd0, d}, 64'd0);
        @(negedge clk);
        check("t1_pulse", {62'd0, rsp_valid}, 64'd0);
        check("t1_loopback", {32'd0, tx_reg}, 64'h6);

        // client 1 reads RX_DATA with a 4-cycle rvalid delay
        @(posedge clk); #1;
        r_delay = 4; b0 = rr_hi; b1 = ar_hi;
        issue(1, 1'b0, 32'h0, 32'h0, "t2");
        wait_rsp(v, d, r);
        check("t2_rspv",  {62'd0, v}, 64'd2);
        check("t2_rdata", {32'd0, d}, 64'h6);
        check("t2_resp",  {62'd0, r}, 64'd0);
        check("t2_rready_cycles",  rr_hi - b0, 64'd5);
        check("t2_arvalid_cycles", ar_hi - b1, 64'd1);

        // both clients continuously valid for four transactions
        @(posedge clk); #1;
        r_delay = 0; gbase = grant_q.size(); rbase = rsp_q.size();
        req_write = 2'b00; req_addr = 64'h0; req_valid = 2'b11;
        wait_grants(gbase, 4);
        @(posedge clk); #1;
        req_valid = 2'b00;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (rsp_q.size() - rbase >= 4) break;
        end
        for (int i = 0; i < 4; i++) begin
            gv = (gbase + i < grant_q.size()) ? grant_q[gbase + i] : 2'd3;
            check($sformatf("t3_grant%0d", i), {62'd0, gv}, i % 2);
            gv = (rbase + i < rsp_q.size()) ? rsp_q[rbase + i] : 2'd3;
            check($sformatf("t3_rsp%0d", i), {62'd0, gv}, i % 2);
        end

        // awready held off 3 cycles, wready immediate
        @(posedge clk); #1;
        aw_delay = 3; b0 = aw_hi; b1 = w_hi;
        issue(0, 1'b1, 32'h4, 32'h55, "t4");
        wait_rsp(v, d, r);
        check("t4_rspv", {62'd0, v}, 64'd1);
        check("t4_resp", {62'd0, r}, 64'd0);
        check("t4_awvalid_cycles", aw_hi - b0, 64'd4);
        check("t4_wvalid_cycles",  w_hi - b1,  64'd1);

        // SLVERR forwarded, then a normal request
        @(posedge clk); #1;
        aw_delay = 0;
        issue(1, 1'b1, 32'h8, 32'h77, "t5");
        wait_rsp(v, d, r);
        check("t5_rspv", {62'd0, v}, 64'd2);
        check("t5_resp", {62'd0, r}, 64'h2);
        check("t5_rdata", {32'd0, d}, 64'd0);
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h0, 32'h0, "t5b");
        wait_rsp(v, d, r);
        check("t5b_rspv",  {62'd0, v}, 64'd1);
        check("t5b_rdata", {32'd0, d}, 64'h55);
        check("t5b_resp",  {62'd0, r}, 64'd0);

        // reset pulse while waiting in RD_R
        @(posedge clk); #1;
        r_delay = 6;
        issue(0, 1'b0, 32'h0, 32'h0, "t6");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rready) break;
        end
        check("t6_in_rd_r", {63'd0, rready}, 64'd1);
        rbase = rsp_q.size();
        @(posedge clk); #1;
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        check("t6_after_rst", {60'd0, arvalid, rready, rsp_valid}, 64'd0);
        repeat (10) @(negedge clk);
        #1;
        check("t6_no_rsp", rsp_q.size() - rbase, 64'd0);
        @(posedge clk); #1;
        r_delay = 0; gbase = grant_q.size();
        req_valid = 2'b11;
        wait_grants(gbase, 1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        gv = (gbase < grant_q.size()) ? grant_q[gbase] : 2'd3;
        check("t6_grant", {62'd0, gv}, 64'd0);
        wait_rsp(v, d, r);
        check("t6_rspv", {62'd0, v}, 64'd1);

        check("onehot_ready",  onehot_err, 64'd0);
        check("ready_busy",    busy_err,   64'd0);
        check("bready_order",  order_err,  64'd0);
        check("rsp_both",      rsp_err,    64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
